// File: rtl/dshift_seq_if.sv
// Command and operand-buffer/feed-register bus for the delay-shift feed sequencer.
interface dshift_seq_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned LW = 6
);
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    dir;
    logic          out_valid;
    logic          busy;
    logic          done;

    // Command issuer / observer side
    modport master (
        output start, mode, base_addr, len,
        input  rd_en, rd_addr, dir, out_valid, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, mode, base_addr, len,
        output rd_en, rd_addr, dir, out_valid, busy, done
    );
endinterface

// File: rtl/dshift_seq.sv
// Sequencer for the DEPTH-lane delay-shift feed register: issues an operand
// read burst, steers the feed register direction code in step with the
// returning data, flags valid operands and pulses done at the end.
module dshift_seq #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 10,
    parameter int unsigned LW     = 6,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          sys_rst,
    dshift_seq_if.slave   bus
);

    localparam int unsigned KW = LW + 1;
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [1:0]        dir_q, dir_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [KW-1:0]     thr;

    // Fill threshold: a full column for POS, a landmark pair for NEW modes
    assign thr = (mode_q == 2'b01) ? KW'(DEPTH) : KW'(2);

    // Next-state, read issue, tag pipe, direction and valid generation
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        k_d         = k_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Data for a tag leaving the pipe arrives at the feed register next cycle
        dir_d       = pipe_q[RD_LAT-1] ? mode_q : 2'b00;
        k_d         = (dir_q != 2'b00) ? k_q + KW'(1) : k_q;
        out_valid_d = (dir_q != 2'b00) && ((k_q + KW'(1)) >= thr);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    len_d  = bus.len;
                    k_d    = '0;
                    busy_d = 1'b1;
                    if ((bus.len == '0) || (bus.mode == 2'b00)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.base_addr;
                        cnt_d     = LW'(1);
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == len_q) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                    cnt_d     = cnt_q + LW'(1);
                end
            end
            DRAIN: begin
                // Hold until the last tag has shifted and its valid slot has passed
                if (dcnt_q == DW'(RD_LAT)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Valid-tag pipe: stage 0 tracks rd_en, each stage adds one cycle
        pipe_d[0] = rd_en_d;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            len_q       <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            k_q         <= '0;
            pipe_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            dir_q       <= 2'b00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            k_q         <= k_d;
            pipe_q      <= pipe_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.dir       = dir_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dshift_seq.sv
// Directed bench for dshift_seq: expected waveforms derived per cycle from
// the command (T0-relative windows for rd_en, dir, out_valid, busy, done).
module tb_dshift_seq;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AW     = 10;
    localparam int unsigned LW     = 6;
    localparam int unsigned RD_LAT = 2;

    logic clk;
    logic sys_rst;
    int   n_vec;
    int   n_err;

    dshift_seq_if #(.AW(AW), .LW(LW)) bus ();

    dshift_seq #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .LW     (LW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Expected outputs in cycle T0+t for a command (m, base, len)
    task automatic check_cycle(input int t, input logic [1:0] m, input logic [AW-1:0] base, input int len);
        bit            act;
        int            dn;
        int            thr;
        bit            e_rd;
        logic [1:0]    e_dir;
        bit            e_ov;
        logic [AW-1:0] e_addr;
        act    = (m != 2'b00) && (len != 0);
        dn     = act ? len + int'(RD_LAT) + 2 : 1;
        thr    = (m == 2'b01) ? int'(DEPTH) : 2;
        e_rd   = act && (t >= 1) && (t <= len);
        e_dir  = (act && (t >= int'(RD_LAT) + 1) && (t <= len + int'(RD_LAT))) ? m : 2'b00;
        e_ov   = act && (t >= int'(RD_LAT) + thr + 1) && (t <= len + int'(RD_LAT) + 1);
        e_addr = base + AW'(t - 1);
        chk("rd_en", t, 32'(bus.rd_en), 32'(e_rd));
        if (e_rd) chk("rd_addr", t, 32'(bus.rd_addr), 32'(e_addr));
        chk("dir", t, 32'(bus.dir), 32'(e_dir));
        chk("out_valid", t, 32'(bus.out_valid), 32'(e_ov));
        chk("done", t, 32'(bus.done), 32'(t == dn));
        chk("busy", t, 32'(bus.busy), 32'((t >= 1) && (t <= dn)));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".rd_en"}, 0, 32'(bus.rd_en), 32'(0));
        chk({tag, ".dir"}, 0, 32'(bus.dir), 32'(0));
        chk({tag, ".out_valid"}, 0, 32'(bus.out_valid), 32'(0));
        chk({tag, ".busy"}, 0, 32'(bus.busy), 32'(0));
        chk({tag, ".done"}, 0, 32'(bus.done), 32'(0));
    endtask

    // Issue a command at the current (T0) cycle and check through done+1
    task automatic run_burst(input logic [1:0] m, input logic [AW-1:0] base, input int len, input bit hold);
        int dn;
        dn = ((m != 2'b00) && (len != 0)) ? len + int'(RD_LAT) + 2 : 1;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.base_addr = base;
        bus.len       = LW'(len);
        for (int t = 1; t <= dn + 1; t++) begin
            @(negedge clk);
            if (!hold && t == 1) begin
                // Command fields must have been latched at T0
                bus.start     = 1'b0;
                bus.mode      = ~m;
                bus.base_addr = ~base;
                bus.len       = '0;
            end
            check_cycle(t, m, base, len);
            if (hold && t == dn) bus.start = 1'b0;
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        sys_rst       = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 2'b00;
        bus.base_addr = '0;
        bus.len       = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset.rd_addr", 0, 32'(bus.rd_addr), 32'(0));
        sys_rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // POS full burst, then NEW_1 pair
        run_burst(2'b01, 10'h010, 6, 1'b0);
        run_burst(2'b11, 10'h020, 2, 1'b0);

        // NEW_0 len 3 followed immediately by POS len 4 at done+1
        run_burst(2'b10, 10'h030, 3, 1'b0);
        run_burst(2'b01, 10'h038, 4, 1'b0);

        // Long NEW_1 keeps shifting with the same code
        run_burst(2'b11, 10'h050, 5, 1'b0);

        // POS shorter than the fill threshold: never valid
        run_burst(2'b01, 10'h060, 3, 1'b0);

        // No-op commands
        run_burst(2'b01, 10'h070, 0, 1'b0);
        run_burst(2'b00, 10'h070, 5, 1'b0);

        // Reset pulsed at T0+5 of a POS len 6 burst
        bus.start     = 1'b1;
        bus.mode      = 2'b01;
        bus.base_addr = 10'h100;
        bus.len       = LW'(6);
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            if (t == 1) bus.start = 1'b0;
            check_cycle(t, 2'b01, 10'h100, 6);
            if (t == 5) sys_rst = 1'b1;
        end
        @(negedge clk);
        sys_rst = 1'b0;
        check_idle("abort_t6");
        chk("abort_t6.rd_addr", 6, 32'(bus.rd_addr), 32'(0));
        @(negedge clk);
        check_idle("abort_t7");
        run_burst(2'b01, 10'h040, 6, 1'b0);

        // Start held high through the burst, address wrap
        run_burst(2'b01, 10'h3FE, 4, 1'b1);
        @(negedge clk);
        check_idle("after_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
